uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` requesters. Each requester offers bytes over a valid/ready handshake. The arbiter latches the granted byte and presents it to the transmitter's byte-level valid/ready input. It sits between client logic (console, debug, status reporters) and the single `uart_tx` instance on the board. In packet mode it holds the grant across multi-byte frames so that frames from different clients never interleave on the line.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: byte width.
- `LOCK_TIMEOUT`, 0: cycles spent in LOCK with no byte before the lock is force-released; 0 disables the timeout. Used only when packet mode is compiled in.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester byte offered.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*8 +: 8].
- `req_last`  in  NUM_REQ  byte is the final byte of a frame.
- `req_ready`  out  NUM_REQ  one-hot, combinational; the byte transfers on a rising edge where `req_valid[i] && req_ready[i]`.
- `tx_valid`  out  1  registered; byte available to the transmitter.
- `tx_data`  out  DATA_WIDTH  registered byte.
- `tx_ready`  in  1  transmitter accepts the byte on a rising edge where `tx_valid && tx_ready`.
- `grant_id`  out  clog2(NUM_REQ)  index of the most recently accepted requester.
- `busy`  out  1  high in SEND or LOCK.

## Operation
- States:
  - IDLE: arbitrate.
  - SEND: `tx_valid` high, waiting for `tx_ready`.
  - LOCK: packet mode only; waiting for the next byte from the locked requester.
- Round-robin arbitration:
  - Priority starts at `(last_grant+1) mod NUM_REQ` and searches upward with wrap-around.
  - After reset, requester 0 has highest priority.
- IDLE, any `req_valid` set:
  - The winner w gets `req_ready[w]=1` in the same cycle.
  - At the edge: `tx_data<=req_data[w]`, `grant_id<=w`, `last_grant<=w`, `tx_valid<=1`, next state SEND.
  - The arbiter captures `req_last[w]` internally.
- SEND:
  - All `req_ready` are 0.
  - On `tx_valid && tx_ready`: `tx_valid<=0`.
  - Next state is LOCK if packet mode is compiled in and the captured last flag is 0; otherwise IDLE.
- LOCK:
  - Only `req_ready[grant_id]` may assert, and it asserts whenever `req_valid[grant_id]` is high.
  - Transfer behaves as in IDLE: next state SEND, and the last flag is recaptured.
  - Other requesters stall regardless of their priority.
  - If `LOCK_TIMEOUT>0` and the state has spent LOCK_TIMEOUT consecutive cycles in LOCK with no transfer, the arbiter returns to IDLE. The timeout counter clears on entry to LOCK.
- `tx_data` and `grant_id` hold their values after transfer until the next grant.
- Requesters must hold `req_valid` and `req_data` stable until accepted. The arbiter does not check this.

## Timing
- Reset values:
  - State IDLE.
  - `tx_valid=0`, `tx_data=0`, `grant_id=0`, `busy=0`, `req_ready=0`.
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
  - Lock timer 0.
- Latency:
  - `req_valid` at cycle 0 in IDLE gives `req_ready` at cycle 0 and `tx_valid` at cycle 1.
  - If `tx_ready` was already high, the byte is consumed at the end of cycle 1.
  - The next grant is possible at cycle 2.
  - Maximum throughput is one byte per 2 cycles, far above any baud rate.
- `tx_ready` may stay low for the full character time; the arbiter holds SEND indefinitely.
- Requests that are all simultaneous are served strictly in rotating order; no requester is starved.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronous).
  - The partial byte in `tx_data` is dropped.
  - The lock is released.
- `busy` is combinational from state: high when state ≠ IDLE.

## Configuration
- `UART_ARB_PACKET_LOCK_EN` defined:
  - The LOCK state, `req_last` handling and `LOCK_TIMEOUT` are compiled in.
  - The grant is held from the first byte through the byte with `req_last=1`.
- Not defined:
  - The arbiter re-arbitrates after every byte.
  - `req_last` and `LOCK_TIMEOUT` are ignored.
  - LOCK logic is absent.

## Test plan
- Single byte after reset:
  - Stimulus: `req_valid=4'b0100`, `req_data[2]=8'hA5`, `tx_ready=1`.
  - Response: `req_ready=4'b0100` in the same cycle; next cycle `tx_valid=1`, `tx_data=8'hA5`, `grant_id=2`; then `tx_valid=0`.
- All four requesting continuously, `tx_ready=1`, lock compiled out:
  - Response: grant order 0,1,2,3,0 with data 8'h10,8'h11,8'h12,8'h13,8'h10.
- Stalled transmitter:
  - Stimulus: `tx_ready=0` for 5208 cycles after `tx_valid` rises.
  - Response: `tx_valid` and `tx_data` stay stable; `req_ready` stays 0 throughout; transfer completes on the first `tx_ready=1` edge.
- Packet lock:
  - Stimulus: requester 1 sends 8'h48,8'h49 with `req_last` on the second byte, while requester 0 requests continuously.
  - Response: line order 8'h48,8'h49, then requester 0's byte.
- Lock timeout:
  - Stimulus: `LOCK_TIMEOUT=16`; requester 3 sends one byte with `req_last=0` and then drops `req_valid`.
  - Response: requester 0 is granted exactly 16 cycles after LOCK entry, no earlier.
- Reset mid-frame:
  - Stimulus: drop `reset_n` while in SEND.
  - Response: `tx_valid=0` and `busy=0` with no clock edge; after release, requester 0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_PACKET_LOCK_EN to hold the grant across frames (LOCK state, req_last, LOCK_TIMEOUT).
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND, LOCK} state_t;

    state_t                state;
    logic [IDW-1:0]        last_grant;
    logic [IDW-1:0]        winner;
    logic [IDW-1:0]        cand;
    logic [IDW-1:0]        sel;
    logic                  found;
    logic                  take;
    int                    rr_idx;
    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = 0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(last_grant) + k) % NUM_REQ;
            cand   = IDW'(rr_idx);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel       = winner;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    take              = 1'b1;
                end
            end
`ifdef UART_ARB_PACKET_LOCK_EN
            LOCK: begin
                sel = grant_id;
                if (req_valid[grant_id]) begin
                    req_ready[grant_id] = 1'b1;
                    take                = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);

`ifdef UART_ARB_PACKET_LOCK_EN
    logic last_flag;
    int   lock_timer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            last_flag  <= 1'b0;
            lock_timer <= 0;
        end else if (take) begin
            tx_data    <= req_bytes[sel];
            grant_id   <= sel;
            last_grant <= sel;
            last_flag  <= req_last[sel];
            tx_valid   <= 1'b1;
            state      <= SEND;
        end else begin
            case (state)
                SEND: begin
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        lock_timer <= 0;
                        state      <= last_flag ? IDLE : LOCK;
                    end
                end
                // A silent locked requester loses the line after LOCK_TIMEOUT idle cycles.
                LOCK: begin
                    if (LOCK_TIMEOUT > 0) begin
                        if (lock_timer == LOCK_TIMEOUT - 1) begin
                            state <= IDLE;
                        end else begin
                            lock_timer <= lock_timer + 1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic unused_lock_inputs;
    assign unused_lock_inputs = (^req_last) ^ (LOCK_TIMEOUT != 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
        end else if (take) begin
            tx_data    <= req_bytes[sel];
            grant_id   <= sel;
            last_grant <= sel;
            tx_valid   <= 1'b1;
            state      <= SEND;
        end else if (state == SEND && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter; packet-lock steps build when UART_ARB_PACKET_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
`ifdef UART_ARB_PACKET_LOCK_EN
    localparam int LOCK_TIMEOUT = 16;
`else
    localparam int LOCK_TIMEOUT = 0;
`endif

    logic                          clk;
    logic                          reset_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_valid;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_ready;
    logic [1:0]                    grant_id;
    logic                          busy;

    int checks = 0;
    int passed = 0;
    logic [15:0] exp_q [$];

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .grant_id(grant_id),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                                 input logic [3:0] last, input logic txr);
        req_valid = valid;
        req_data  = data;
        req_last  = last;
        tx_ready  = txr;
    endtask

    task automatic pushExpected(input int id, input logic [7:0] data);
        exp_q.push_back({8'(id), data});
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        stepCycle();
        applyStimulus(4'b0000, 32'h0, 4'hF, 1'b0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    // Scoreboard: every byte handed to the transmitter must match the next expected one.
    always @(negedge clk) begin
        if (reset_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_tx", {24'h0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                checkOutput("sb_tx_data", {24'h0, tx_data}, {24'h0, e[7:0]});
                checkOutput("sb_grant_id", {30'h0, grant_id}, {24'h0, e[15:8]});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stall_errs;
        int lock_errs;

        reset_n = 1'b0;
        applyStimulus(4'b0000, 32'h0, 4'hF, 1'b0);
        #1;
        checkOutput("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        checkOutput("rst_tx_data", {24'h0, tx_data}, 32'h0);
        checkOutput("rst_grant_id", {30'h0, grant_id}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_req_ready", {28'h0, req_ready}, 32'h0);
        #20;
        @(negedge clk);
        reset_n = 1'b1;

        // Single byte from requester 2 right after reset.
        stepCycle();
        applyStimulus(4'b0100, 32'h00A5_0000, 4'hF, 1'b1);
        pushExpected(2, 8'hA5);
        @(negedge clk);
        checkOutput("single_req_ready", {28'h0, req_ready}, 32'h4);
        checkOutput("single_busy_idle", {31'h0, busy}, 32'h0);
        stepCycle();
        applyStimulus(4'b0000, 32'h0, 4'hF, 1'b1);
        @(negedge clk);
        checkOutput("single_tx_valid", {31'h0, tx_valid}, 32'h1);
        checkOutput("single_tx_data", {24'h0, tx_data}, 32'hA5);
        checkOutput("single_grant_id", {30'h0, grant_id}, 32'h2);
        checkOutput("single_busy_send", {31'h0, busy}, 32'h1);
        checkOutput("single_ready_send", {28'h0, req_ready}, 32'h0);
        stepCycle();
        @(negedge clk);
        checkOutput("single_tx_valid_done", {31'h0, tx_valid}, 32'h0);
        checkOutput("single_tx_data_hold", {24'h0, tx_data}, 32'hA5);
        checkOutput("single_grant_hold", {30'h0, grant_id}, 32'h2);

        // All four requesting continuously: strict rotation 0,1,2,3,0.
        doReset();
        stepCycle();
        applyStimulus(4'b1111, 32'h1312_1110, 4'hF, 1'b1);
        pushExpected(0, 8'h10);
        pushExpected(1, 8'h11);
        pushExpected(2, 8'h12);
        pushExpected(3, 8'h13);
        pushExpected(0, 8'h10);
        repeat (9) stepCycle();
        applyStimulus(4'b0000, 32'h0, 4'hF, 1'b1);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("rr_queue_empty", exp_q.size(), 32'h0);
        checkOutput("rr_tx_idle", {31'h0, tx_valid}, 32'h0);

        // Stalled transmitter: requester 1 wins, then tx_ready stays low for 5208 cycles.
        stepCycle();
        applyStimulus(4'b0111, 32'h002A_5C1F, 4'hF, 1'b0);
        pushExpected(1, 8'h5C);
        @(negedge clk);
        checkOutput("stall_req_ready", {28'h0, req_ready}, 32'h2);
        stepCycle();
        applyStimulus(4'b0101, 32'h002A_001F, 4'hF, 1'b0);
        stall_errs = 0;
        for (int k = 0; k < 5208; k++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h5C || req_ready !== 4'b0000 || grant_id !== 2'd1)
                stall_errs++;
            stepCycle();
        end
        applyStimulus(4'b0000, 32'h0, 4'hF, 1'b1);
        @(negedge clk);
        checkOutput("stall_hold_errors", stall_errs, 32'h0);
        checkOutput("stall_tx_valid_before", {31'h0, tx_valid}, 32'h1);
        stepCycle();
        @(negedge clk);
        checkOutput("stall_tx_valid_after", {31'h0, tx_valid}, 32'h0);
        checkOutput("stall_busy_after", {31'h0, busy}, 32'h0);
        checkOutput("stall_queue_empty", exp_q.size(), 32'h0);

        // Reset asserted while a byte sits in SEND.
        stepCycle();
        applyStimulus(4'b1000, 32'h6600_0000, 4'hF, 1'b0);
        stepCycle();
        @(negedge clk);
        checkOutput("midrst_busy_before", {31'h0, busy}, 32'h1);
        checkOutput("midrst_tx_valid_before", {31'h0, tx_valid}, 32'h1);
        #2;
        applyStimulus(4'b0000, 32'h0, 4'hF, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
        checkOutput("midrst_tx_data", {24'h0, tx_data}, 32'h0);
        checkOutput("midrst_grant_id", {30'h0, grant_id}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        stepCycle();
        applyStimulus(4'b1111, 32'h4433_2211, 4'hF, 1'b1);
        pushExpected(0, 8'h11);
        @(negedge clk);
        checkOutput("midrst_first_winner", {28'h0, req_ready}, 32'h1);
        stepCycle();
        applyStimulus(4'b0000, 32'h0, 4'hF, 1'b1);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("midrst_queue_empty", exp_q.size(), 32'h0);

`ifdef UART_ARB_PACKET_LOCK_EN
        // Packet lock: requester 1 frame 48,49 must not be split by requester 0.
        doReset();
        stepCycle();
        applyStimulus(4'b0010, 32'h0000_4800, 4'b0000, 1'b1);
        pushExpected(1, 8'h48);
        pushExpected(1, 8'h49);
        pushExpected(0, 8'h30);
        @(negedge clk);
        checkOutput("pkt_first_ready", {28'h0, req_ready}, 32'h2);
        stepCycle();
        applyStimulus(4'b0011, 32'h0000_4930, 4'b0011, 1'b1);
        @(negedge clk);
        checkOutput("pkt_send_ready", {28'h0, req_ready}, 32'h0);
        stepCycle();
        @(negedge clk);
        checkOutput("pkt_lock_ready", {28'h0, req_ready}, 32'h2);
        checkOutput("pkt_lock_busy", {31'h0, busy}, 32'h1);
        stepCycle();
        applyStimulus(4'b0001, 32'h0000_0030, 4'b0001, 1'b1);
        stepCycle();
        @(negedge clk);
        checkOutput("pkt_release_ready", {28'h0, req_ready}, 32'h1);
        stepCycle();
        applyStimulus(4'b0000, 32'h0, 4'hF, 1'b1);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("pkt_queue_empty", exp_q.size(), 32'h0);

        // Lock timeout: requester 3 goes silent mid-frame, requester 0 waits exactly 16 cycles.
        doReset();
        stepCycle();
        applyStimulus(4'b1000, 32'h7700_0000, 4'b0000, 1'b1);
        pushExpected(3, 8'h77);
        pushExpected(0, 8'h31);
        stepCycle();
        applyStimulus(4'b0001, 32'h0000_0031, 4'b0001, 1'b1);
        stepCycle();
        lock_errs = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (req_ready !== 4'b0000 || busy !== 1'b1)
                lock_errs++;
            stepCycle();
        end
        @(negedge clk);
        checkOutput("timeout_early_grant", lock_errs, 32'h0);
        checkOutput("timeout_grant", {28'h0, req_ready}, 32'h1);
        stepCycle();
        applyStimulus(4'b0000, 32'h0, 4'hF, 1'b1);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("timeout_queue_empty", exp_q.size(), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
